// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder/subtractor that works through WIDTH-bit
// operands BITS_PER_CYCLE bits per clock, LSB chunk first. A registered carry
// links the chunks. Start/busy/done handshake. The result holds until the next
// operation completes.
//
// Parameters:
//   WIDTH           operand/result width; must be a multiple of BITS_PER_CYCLE
//   BITS_PER_CYCLE  bits added per clock (>= 1, divides WIDTH)
//
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   request pulse, sampled only while idle
//   sub    in   0: a + b + cin, 1: a - b (a + ~b + 1, cin ignored)
//   a, b   in   operands, captured on an accepted start
//   cin    in   carry-in, captured on an accepted start
//   sum    out  registered result
//   cout   out  carry-out of bit WIDTH (for sub: 1 = no borrow)
//   busy   out  operation in progress
//   done   out  one-cycle pulse when sum/cout are updated
//   ovf    out  signed overflow (only when SERIAL_ADDER_OVF_EN is defined)
//
// Build option: define SERIAL_ADDER_OVF_EN to add the ovf port and its logic.

module serial_adder #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned BPC    = BITS_PER_CYCLE;
  localparam int unsigned N      = WIDTH / BPC;
  localparam int unsigned CNT_W  = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CHK_W  = BPC + 1;
  localparam int unsigned CAT_W  = WIDTH + BPC;

  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(N - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  // State and datapath registers
  logic [0:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] res_sr;

  // Next-state values
  logic [0:0]       state_nxt;
  logic [WIDTH-1:0] a_nxt;
  logic [WIDTH-1:0] b_nxt;
  logic             carry_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [WIDTH-1:0] res_nxt;
  logic [WIDTH-1:0] sum_nxt;
  logic             cout_nxt;
  logic             busy_nxt;
  logic             done_nxt;

  // Chunk adder: low BPC bits of both shift registers plus the running carry
  logic [CHK_W-1:0] chunk;
  assign chunk = CHK_W'(a_sr[BPC-1:0]) + CHK_W'(b_sr[BPC-1:0]) + CHK_W'(carry);

  // New chunk enters the result register from the MSB side
  logic [CAT_W-1:0] res_cat;
  logic [WIDTH-1:0] res_shift;
  assign res_cat   = {chunk[BPC-1:0], res_sr};
  assign res_shift = res_cat[CAT_W-1:BPC];

`ifdef SERIAL_ADDER_OVF_EN
  // Carry into the top bit of the chunk, recovered from its sum bit and inputs;
  // on the last chunk this is the carry into bit WIDTH-1.
  logic msb_cin;
  logic ovf_nxt;
  assign msb_cin = chunk[BPC-1] ^ a_sr[BPC-1] ^ b_sr[BPC-1];
`endif

  // Next-state and output logic
  always_comb begin
    state_nxt = state;
    a_nxt     = a_sr;
    b_nxt     = b_sr;
    carry_nxt = carry;
    cnt_nxt   = cnt;
    res_nxt   = res_sr;
    sum_nxt   = sum;
    cout_nxt  = cout;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_nxt   = ovf;
`endif

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          a_nxt     = a;
          b_nxt     = sub ? ~b : b;
          carry_nxt = sub ? 1'b1 : cin;
          cnt_nxt   = '0;
          res_nxt   = '0;
          busy_nxt  = 1'b1;
        end
      end

      RUN: begin
        a_nxt     = a_sr >> BPC;
        b_nxt     = b_sr >> BPC;
        carry_nxt = chunk[BPC];
        cnt_nxt   = cnt + CNT_W'(1);
        res_nxt   = res_shift;
        if (cnt == LAST_CHUNK) begin
          state_nxt = IDLE;
          sum_nxt   = res_shift;
          cout_nxt  = chunk[BPC];
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
`ifdef SERIAL_ADDER_OVF_EN
          ovf_nxt   = msb_cin ^ chunk[BPC];
`endif
        end
      end

      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      res_sr <= '0;
      sum    <= '0;
      cout   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      a_sr   <= a_nxt;
      b_sr   <= b_nxt;
      carry  <= carry_nxt;
      cnt    <= cnt_nxt;
      res_sr <= res_nxt;
      sum    <= sum_nxt;
      cout   <= cout_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  // Signed overflow flag, updated only on the completion edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else begin
      ovf <= ovf_nxt;
    end
  end
`endif

endmodule
